// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C observer decoding START/STOP, address and data bytes into a FWFT FIFO
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic [2:0] state_o,
    output logic       op_o,
    output logic [6:0] addr_o,
    output logic       addr_valid_o,
    output logic       busy_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_ack_o,
    output logic       byte_op_o,
    input  logic       byte_ready_i,
    output logic       overflow_o,
    input  logic       clr_overflow_i
);
    typedef enum logic [2:0] {WAIT = 3'd0, START = 3'd1, STOP = 3'd2, RECEIVE = 3'd3, SEND = 3'd4, ADDR = 3'd5} i2c_state_t;
    typedef enum logic {WRITE = 1'b0, READ = 1'b1} i2c_op_t;
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_p, sda_p, scl_s, sda_s, start, stop, sample;
    i2c_state_t state, state_n;
    i2c_op_t op, op_n;
    logic [3:0] bit_cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [6:0] addr, addr_n;
    logic addr_valid, av_n, push, pop, wr_en, empty, full;
    logic [9:0] mem [FIFO_DEPTH];
    logic [9:0] head;
    logic [AW:0] wr_ptr, rd_ptr;
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
    assign start = scl_p & scl_s & sda_p & ~sda_s;
    assign stop = scl_p & scl_s & ~sda_p & sda_s;
    assign sample = ~scl_p & scl_s;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_p <= scl_s;
            sda_p <= sda_s;
        end
    end
    // START also serves as repeated start: any partial byte is dropped by clearing the counter
    always_comb begin
        state_n = state;
        cnt_n = bit_cnt;
        shreg_n = shreg;
        op_n = op;
        addr_n = addr;
        av_n = 1'b0;
        push = 1'b0;
        if (start) begin
            state_n = START;
            cnt_n = '0;
        end else if (stop) begin
            state_n = STOP;
            cnt_n = '0;
        end else if (state == START) begin
            state_n = ADDR;
        end else if (state == STOP) begin
            state_n = WAIT;
        end else if (sample && state != WAIT) begin
            if (bit_cnt != 4'd8) begin
                shreg_n = {shreg[6:0], sda_s};
                cnt_n = bit_cnt + 4'd1;
            end else begin
                cnt_n = '0;
                if (state == ADDR) begin
                    addr_n = shreg[7:1];
                    op_n = i2c_op_t'(shreg[0]);
                    av_n = 1'b1;
                    state_n = sda_s ? WAIT : (shreg[0] ? SEND : RECEIVE);
                end else begin
                    push = 1'b1;
                    state_n = sda_s ? WAIT : state;
                end
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WAIT;
            bit_cnt <= '0;
            shreg <= '0;
            op <= WRITE;
            addr <= '0;
            addr_valid <= 1'b0;
        end else begin
            state <= state_n;
            bit_cnt <= cnt_n;
            shreg <= shreg_n;
            op <= op_n;
            addr <= addr_n;
            addr_valid <= av_n;
        end
    end
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop = ~empty & byte_ready_i;
    assign wr_en = push & (~full | pop);
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {op, sda_s, shreg};
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push & full & ~pop) overflow_o <= 1'b1;
            else if (clr_overflow_i) overflow_o <= 1'b0;
        end
    end
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign {byte_op_o, byte_ack_o, byte_data_o} = head;
    assign byte_valid_o = ~empty;
    assign state_o = state;
    assign op_o = op;
    assign addr_o = addr;
    assign addr_valid_o = addr_valid;
    assign busy_o = state != WAIT && state != STOP;
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: directed I2C transactions against hand-computed decode and FIFO expectations
`timescale 1ns/1ps
module tb_i2c_bus_monitor;
    localparam int H = 6;
    logic clk_i = 1'b0, rst_i = 1'b1, scl_i = 1'b1, sda_i = 1'b1, byte_ready_i = 1'b0, clr_overflow_i = 1'b0;
    logic [2:0] state_o;
    logic op_o, addr_valid_o, busy_o, byte_valid_o, byte_ack_o, byte_op_o, overflow_o;
    logic [6:0] addr_o;
    logic [7:0] byte_data_o;
    int n_chk = 0, n_pass = 0, av_cnt = 0, av0;
    logic [2:0] last_state = 3'd0;
    logic [2:0] trace[$];

    typedef struct {
        logic [6:0] addr;
        logic rw;
        logic aack;
        int nb;
        logic [1:0][7:0] d;
        logic [1:0] k;
        int tn;
        logic [5:0][2:0] tr;
        int en;
        logic [1:0][9:0] ent;
    } vec_t;
    vec_t vec[3];

    i2c_bus_monitor dut (
        .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i),
        .state_o(state_o), .op_o(op_o), .addr_o(addr_o), .addr_valid_o(addr_valid_o),
        .busy_o(busy_o), .byte_valid_o(byte_valid_o), .byte_data_o(byte_data_o),
        .byte_ack_o(byte_ack_o), .byte_op_o(byte_op_o), .byte_ready_i(byte_ready_i),
        .overflow_o(overflow_o), .clr_overflow_i(clr_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (state_o !== last_state) begin
            trace.push_back(state_o);
            last_state = state_o;
        end
        if (addr_valid_o === 1'b1) av_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_h();
        repeat (H) @(negedge clk_i);
    endtask

    task automatic do_start();
        sda_i = 1'b1; wait_h();
        scl_i = 1'b1; wait_h();
        sda_i = 1'b0; wait_h();
        scl_i = 1'b0; wait_h();
    endtask

    task automatic do_stop();
        sda_i = 1'b0; wait_h();
        scl_i = 1'b1; wait_h();
        sda_i = 1'b1; wait_h(); wait_h();
    endtask

    task automatic send_bit(input logic b);
        sda_i = b; wait_h();
        scl_i = 1'b1; wait_h();
        scl_i = 1'b0; wait_h();
    endtask

    // raises byte_ready_i exactly in the cycle the monitor pushes this bit's byte
    task automatic send_bit_pop(input logic b);
        sda_i = b; wait_h();
        scl_i = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        byte_ready_i = 1'b1;
        @(negedge clk_i);
        byte_ready_i = 1'b0;
        repeat (H - 3) @(negedge clk_i);
        scl_i = 1'b0; wait_h();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic pop_check(input string name, input logic [9:0] exp);
        chk({name, "_valid"}, 32'(byte_valid_o), 32'd1);
        chk({name, "_entry"}, 32'({byte_op_o, byte_ack_o, byte_data_o}), 32'(exp));
        byte_ready_i = 1'b1;
        @(negedge clk_i);
        byte_ready_i = 1'b0;
    endtask

    task automatic run_tx(input vec_t v);
        do_start();
        send_byte({v.addr, v.rw});
        send_bit(v.aack);
        for (int i = 0; i < v.nb; i++) begin
            send_byte(v.d[i]);
            send_bit(v.k[i]);
        end
        do_stop();
    endtask

    initial begin
        vec[0] = '{7'h22, 1'b0, 1'b0, 2, {8'h3C, 8'hA5}, 2'b10, 6,
                   {3'd0, 3'd2, 3'd0, 3'd3, 3'd5, 3'd1}, 2, {10'h13C, 10'h0A5}};
        vec[1] = '{7'h51, 1'b1, 1'b0, 2, {8'h34, 8'h12}, 2'b10, 6,
                   {3'd0, 3'd2, 3'd0, 3'd4, 3'd5, 3'd1}, 2, {10'h334, 10'h212}};
        vec[2] = '{7'h7F, 1'b0, 1'b1, 0, {8'h00, 8'h00}, 2'b00, 5,
                   {3'd0, 3'd0, 3'd2, 3'd0, 3'd5, 3'd1}, 0, {10'h000, 10'h000}};

        repeat (3) @(negedge clk_i);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_outs", 32'({op_o, addr_o, addr_valid_o, busy_o, byte_valid_o, byte_data_o, byte_ack_o, byte_op_o, overflow_o}), 32'd0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("idle_state", 32'(state_o), 32'd0);

        sda_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        chk("lat_before", 32'(state_o), 32'd0);
        @(negedge clk_i);
        chk("lat_start", 32'(state_o), 32'd1);
        chk("lat_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        chk("lat_addr", 32'(state_o), 32'd5);
        sda_i = 1'b1; wait_h(); wait_h();
        chk("lat_stop_wait", 32'(state_o), 32'd0);
        chk("lat_stop_busy", 32'(busy_o), 32'd0);

        for (int v = 0; v < 3; v++) begin
            trace.delete();
            av0 = av_cnt;
            run_tx(vec[v]);
            chk($sformatf("v%0d_trace_len", v), 32'(trace.size()), 32'(vec[v].tn));
            for (int j = 0; j < vec[v].tn; j++)
                chk($sformatf("v%0d_trace%0d", v, j), 32'(j < trace.size() ? trace[j] : 3'h7), 32'(vec[v].tr[j]));
            chk($sformatf("v%0d_av_pulses", v), 32'(av_cnt - av0), 32'd1);
            chk($sformatf("v%0d_addr", v), 32'(addr_o), 32'(vec[v].addr));
            chk($sformatf("v%0d_op", v), 32'(op_o), 32'(vec[v].rw));
            for (int j = 0; j < vec[v].en; j++) pop_check($sformatf("v%0d_pop%0d", v, j), vec[v].ent[j]);
            chk($sformatf("v%0d_empty", v), 32'(byte_valid_o), 32'd0);
        end

        trace.delete();
        av0 = av_cnt;
        do_start();
        send_byte({7'h22, 1'b0});
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_start();
        send_byte({7'h10, 1'b1});
        send_bit(1'b0);
        chk("rs_state_send", 32'(state_o), 32'd4);
        do_stop();
        chk("rs_av_pulses", 32'(av_cnt - av0), 32'd2);
        chk("rs_addr", 32'(addr_o), 32'h10);
        chk("rs_op", 32'(op_o), 32'd1);
        chk("rs_no_push", 32'(byte_valid_o), 32'd0);
        chk("rs_trace_len", 32'(trace.size()), 32'd8);
        chk("rs_trace_start2", 32'(trace.size() > 3 ? trace[3] : 3'h7), 32'd1);

        do_start();
        send_byte({7'h33, 1'b0});
        send_bit(1'b0);
        send_byte(8'h81); send_bit(1'b0);
        send_byte(8'h42); send_bit(1'b0);
        send_byte(8'h24); send_bit(1'b0);
        send_byte(8'h18); send_bit(1'b0);
        chk("ov_full_no_ovf", 32'(overflow_o), 32'd0);
        send_byte(8'hFF); send_bit(1'b0);
        chk("ov_set", 32'(overflow_o), 32'd1);
        clr_overflow_i = 1'b1;
        @(negedge clk_i);
        clr_overflow_i = 1'b0;
        chk("ov_clr", 32'(overflow_o), 32'd0);
        send_byte(8'h5A);
        send_bit_pop(1'b0);
        chk("ov_pushpop_full", 32'(overflow_o), 32'd0);
        do_stop();
        pop_check("ov_pop0", 10'h042);
        pop_check("ov_pop1", 10'h024);
        pop_check("ov_pop2", 10'h018);
        pop_check("ov_pop3", 10'h05A);
        chk("ov_empty", 32'(byte_valid_o), 32'd0);

        do_start();
        send_byte({7'h22, 1'b0});
        send_bit(1'b0);
        send_byte(8'h11); send_bit(1'b0);
        send_byte(8'h22); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("mr_queued", 32'(byte_valid_o), 32'd1);
        chk("mr_state_rx", 32'(state_o), 32'd3);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("mr_state", 32'(state_o), 32'd0);
        chk("mr_valid", 32'(byte_valid_o), 32'd0);
        chk("mr_outs", 32'({busy_o, addr_o, op_o, byte_data_o, overflow_o}), 32'd0);
        sda_i = 1'b1; wait_h();
        scl_i = 1'b1; wait_h(); wait_h();
        chk("mr_idle", 32'(state_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Synthesizable passive I2C bus observer; samples raw SCL/SDA on the system clock, detects START/STOP, decodes address, R/W and data bytes with ACK.
- Publishes bus phase using the shared globals encodings (i2c_state_t, i2c_op_t).
- Buffers decoded bytes in a small first-word-fall-through FIFO with valid/ready handshake.
- Sits between the I2C pins and the checker/predictor; never drives the bus.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input (min 2)
FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
scl_i  in  1  raw SCL
sda_i  in  1  raw SDA
state_o  out  3  i2c_state_t: WAIT=0, START=1, STOP=2, RECEIVE=3, SEND=4, ADDR=5
op_o  out  1  i2c_op_t of current transfer: WRITE=0, READ=1
addr_o  out  7  latched target address
addr_valid_o  out  1  one-cycle pulse when address byte plus ACK bit complete
busy_o  out  1  high from START until STOP/WAIT
byte_valid_o  out  1  FIFO non-empty
byte_data_o  out  8  head entry data
byte_ack_o  out  1  head entry ACK bit (0=ACK, 1=NACK)
byte_op_o  out  1  head entry op
byte_ready_i  in  1  consumer pop
overflow_o  out  1  sticky: byte dropped on full FIFO
clr_overflow_i  in  1  clears overflow_o

Behaviour:
- Reset (sync, rst_i=1): state_o=WAIT; op_o=0; addr_o=0; addr_valid_o=0; busy_o=0; FIFO empty (byte_valid_o=0, byte_data_o/byte_ack_o/byte_op_o=0); overflow_o=0; bit counter=0; synchronizer and previous-sample registers load 1 (bus idle).
- Input sampling: SYNC_STAGES-flop synchronizer, then previous-sample register. s=synced value, p=previous value.
- Events, evaluated combinationally from s/p:
  - start = scl_p & scl_s & sda_p & ~sda_s
  - stop = scl_p & scl_s & ~sda_p & sda_s
  - sample = ~scl_p & scl_s; shifts sda_s in MSB first.
  - SCL and SDA both changing in the same synced cycle counts as sample only.
- Latency: state_o changes exactly SYNC_STAGES+1 clk cycles after the first clk edge that sees the pin change.
- State machine:
  - start in any state -> START for 1 cycle, bit counter=0, partial byte discarded (covers repeated start).
  - START -> ADDR.
  - ADDR: 9 samples (7 addr bits, R/W, ACK). On the 9th sample, load addr_o/op_o and pulse addr_valid_o. Then:
    - ACK and op=WRITE -> RECEIVE
    - ACK and op=READ -> SEND
    - NACK -> WAIT
  - RECEIVE/SEND: every 9th sample pushes {op, ack, data} to FIFO and resets counter. NACK -> WAIT after push; ACK -> stay.
  - stop in any state -> STOP for 1 cycle, then WAIT; partial byte discarded, no push.
  - WAIT ignores samples.
  - start/stop take priority over sample (mutually exclusive by construction).
- busy_o = state != WAIT && state != STOP.
- FIFO:
  - Pop when byte_valid_o & byte_ready_i; head outputs are valid whenever byte_valid_o=1.
  - Push on full without same-cycle pop: entry dropped, overflow_o<=1.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Push and pop in the same cycle when empty: the pushed entry appears next cycle; nothing is popped.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow_o stays set until clr_overflow_i=1. If clr_overflow_i and an overflow occur in the same cycle, set wins.
- Reset mid-transfer: everything returns to reset values on the next edge; FIFO contents discarded.

Test Plan:
1. Hold rst_i 3 cycles with bus idle -> every output at its reset value, state_o=0; after release stays WAIT.
2. Write: START, addr 0x22 W, ACK, 0xA5 ACK, 0x3C NACK, STOP ->
   - state_o sequence START, ADDR, RECEIVE, WAIT, STOP, WAIT
   - addr_valid_o single pulse with addr_o=0x22, op_o=0
   - FIFO pops {0,0,0xA5} then {0,1,0x3C}
3. Read: START, addr 0x51 R, ACK, 0x12 ACK, 0x34 NACK, STOP -> state_o=SEND; entries {1,0,0x12}, {1,1,0x34}; WAIT after NACK; STOP then WAIT.
4. Repeated start after 3 data bits of a write, then addr 0x10 R ->
   - no push for the partial byte
   - START pulse, then second addr_valid_o with addr_o=0x10, op_o=1
5. byte_ready_i=0, write 5 bytes with FIFO_DEPTH=4 ->
   - FIFO holds the first 4 bytes; overflow_o=1 at the 5th
   - clr_overflow_i clears it
   - with FIFO full, byte_ready_i=1 coinciding with a 6th push -> no overflow, count stays 4
6. Address 0x7F NACK -> state WAIT, no FIFO push. Separately, assert rst_i mid-data-byte with 2 entries queued -> WAIT, byte_valid_o=0.
